// File: rtl/uart_receiver.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling FSM, and a one-byte
// holding register behind a valid/ready handshake with framing/overrun pulses.
module uart_receiver #(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    input  logic       data_out_ready,
    output logic       framing_error,
    output logic       overrun
);

    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
    localparam int CNT_W            = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;
    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_TIME - 1);
    localparam logic [CNT_W-1:0] SYMBOL_LAST = CNT_W'(SYMBOL_EDGE_TIME - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    logic [1:0]       sync;
    logic             rx;
    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [2:0]       bit_idx, idx_nx;
    logic [7:0]       shreg, shreg_nx;
    logic             deliver, deliver_nx;
    logic             fe_nx;

    // Line idles high, so the synchroniser resets to 1 to avoid a phantom start bit.
    always_ff @(posedge clk) begin
        if (rst) sync <= 2'b11;
        else     sync <= {sync[0], serial_in};
    end
    assign rx = sync[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            bit_idx       <= '0;
            shreg         <= '0;
            deliver       <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            state         <= state_nx;
            cnt           <= cnt_nx;
            bit_idx       <= idx_nx;
            shreg         <= shreg_nx;
            deliver       <= deliver_nx;
            framing_error <= fe_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        idx_nx     = bit_idx;
        shreg_nx   = shreg;
        deliver_nx = 1'b0;
        fe_nx      = 1'b0;
        case (state)
            IDLE: begin
                if (!rx) begin
                    state_nx = START;
                    cnt_nx   = '0;
                end
            end
            START: begin
                if (cnt == SAMPLE_LAST) begin
                    if (rx) begin
                        state_nx = IDLE;
                    end else begin
                        state_nx = DATA;
                        cnt_nx   = '0;
                        idx_nx   = '0;
                    end
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            // Counter was re-zeroed at the start mid-point, so full-symbol waits stay at mid-bit.
            DATA: begin
                if (cnt == SYMBOL_LAST) begin
                    cnt_nx            = '0;
                    shreg_nx[bit_idx] = rx;
                    idx_nx            = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) state_nx = STOP;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            STOP: begin
                if (cnt == SYMBOL_LAST) begin
                    cnt_nx = '0;
                    if (rx) begin
                        deliver_nx = 1'b1;
                        state_nx   = IDLE;
                    end else begin
                        fe_nx    = 1'b1;
                        state_nx = BREAK;
                    end
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            BREAK: begin
                if (rx) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // A consume in the delivery cycle frees the register, so the new byte reloads it.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out       <= '0;
            data_out_valid <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (deliver) begin
                if (!data_out_valid || data_out_ready) begin
                    data_out       <= shreg;
                    data_out_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (data_out_valid && data_out_ready) begin
                data_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 10 clocks per bit: latency, overrun,
// same-cycle reload, framing/break, glitch rejection and mid-frame reset.
module tb_uart_receiver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       serial_in = 1'b1;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_out_ready = 1'b0;
    logic       framing_error;
    logic       overrun;

    int n_checks = 0;
    int n_fail   = 0;
    int fe_cnt = 0, ov_cnt = 0, both_cnt = 0, vrise = 0;
    logic prev_valid = 1'b0;

    uart_receiver #(.CLOCK_FREQ(1_152_000), .BAUD_RATE(115_200)) dut (
        .clk           (clk),
        .rst           (rst),
        .serial_in     (serial_in),
        .data_out      (data_out),
        .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready),
        .framing_error (framing_error),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (framing_error) fe_cnt <= fe_cnt + 1;
            if (overrun) ov_cnt <= ov_cnt + 1;
            if (framing_error && overrun) both_cnt <= both_cnt + 1;
            if (data_out_valid && !prev_valid) vrise <= vrise + 1;
        end
        prev_valid <= data_out_valid;
    end

    // Called just after a rising edge; returns just after the edge ending the stop bit.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            serial_in = fr[i];
            repeat (10) @(posedge clk);
            #1;
        end
    endtask

    task automatic consume();
        data_out_ready = 1'b1;
        @(posedge clk); #1;
        data_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data got=%h exp=00", data_out); end
        n_checks++; if (data_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", data_out_valid); end
        n_checks++; if (framing_error !== 1'b0) begin n_fail++; $display("FAIL reset_fe got=%b exp=0", framing_error); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_ov got=%b exp=0", overrun); end
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic test_latency();
        int fe0, ov0, lat;
        logic got;
        logic [7:0] d;
        fe0 = fe_cnt; ov0 = ov_cnt; lat = 0; got = 1'b0; d = 8'h00;
        data_out_ready = 1'b1;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                @(posedge clk);
                while (lat < 200 && !got) begin
                    @(posedge clk); #1;
                    lat++;
                    if (data_out_valid) begin got = 1'b1; d = data_out; end
                end
            end
        join
        data_out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (!got) begin n_fail++; $display("FAIL lat_timeout got=none exp=valid within 200"); end
        n_checks++; if (lat != 98) begin n_fail++; $display("FAIL lat_cycles got=%0d exp=98", lat); end
        n_checks++; if (d !== 8'hA5) begin n_fail++; $display("FAIL lat_data got=%h exp=a5", d); end
        n_checks++; if (fe_cnt - fe0 != 0) begin n_fail++; $display("FAIL lat_fe got=%0d exp=0", fe_cnt - fe0); end
        n_checks++; if (ov_cnt - ov0 != 0) begin n_fail++; $display("FAIL lat_ov got=%0d exp=0", ov_cnt - ov0); end
    endtask

    task automatic test_overrun();
        int ov0, fe0;
        ov0 = ov_cnt; fe0 = fe_cnt;
        send_frame(8'h3C, 1'b1);
        send_frame(8'h81, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        n_checks++; if (data_out !== 8'h3C) begin n_fail++; $display("FAIL ovr_data got=%h exp=3c", data_out); end
        n_checks++; if (data_out_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid got=%b exp=1", data_out_valid); end
        n_checks++; if (ov_cnt - ov0 != 1) begin n_fail++; $display("FAIL ovr_pulses got=%0d exp=1", ov_cnt - ov0); end
        n_checks++; if (fe_cnt - fe0 != 0) begin n_fail++; $display("FAIL ovr_fe got=%0d exp=0", fe_cnt - fe0); end
        consume();
        n_checks++; if (data_out_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_consume got=%b exp=0", data_out_valid); end
    endtask

    task automatic test_reload();
        int ov0;
        logic [7:0] d;
        logic v;
        send_frame(8'h55, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (data_out !== 8'h55) begin n_fail++; $display("FAIL rld_first got=%h exp=55", data_out); end
        ov0 = ov_cnt; d = 8'h00; v = 1'b0;
        fork
            send_frame(8'h0F, 1'b1);
            begin
                @(posedge clk);
                repeat (97) @(posedge clk);
                #1 data_out_ready = 1'b1;
                @(posedge clk); #1;
                data_out_ready = 1'b0;
                d = data_out; v = data_out_valid;
            end
        join
        n_checks++; if (d !== 8'h0F) begin n_fail++; $display("FAIL rld_data got=%h exp=0f", d); end
        n_checks++; if (v !== 1'b1) begin n_fail++; $display("FAIL rld_valid got=%b exp=1", v); end
        n_checks++; if (ov_cnt - ov0 != 0) begin n_fail++; $display("FAIL rld_ov got=%0d exp=0", ov_cnt - ov0); end
        consume();
    endtask

    task automatic test_framing();
        int fe0, vr0;
        fe0 = fe_cnt; vr0 = vrise;
        send_frame(8'h7E, 1'b0);
        repeat (30) @(posedge clk);
        #1 serial_in = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        n_checks++; if (fe_cnt - fe0 != 1) begin n_fail++; $display("FAIL frm_pulses got=%0d exp=1", fe_cnt - fe0); end
        n_checks++; if (vrise - vr0 != 0 || data_out_valid !== 1'b0) begin n_fail++; $display("FAIL frm_valid got=%0d rises exp=0", vrise - vr0); end
        send_frame(8'h12, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (data_out !== 8'h12 || data_out_valid !== 1'b1) begin n_fail++; $display("FAIL frm_next got=%h/%b exp=12/1", data_out, data_out_valid); end
        consume();
    endtask

    task automatic test_glitch();
        int fe0, ov0, vr0;
        fe0 = fe_cnt; ov0 = ov_cnt; vr0 = vrise;
        serial_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 serial_in = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        n_checks++; if (vrise - vr0 != 0 || data_out_valid !== 1'b0) begin n_fail++; $display("FAIL gl_valid got=%0d rises exp=0", vrise - vr0); end
        n_checks++; if (fe_cnt - fe0 != 0 || ov_cnt - ov0 != 0) begin n_fail++; $display("FAIL gl_flags got=fe%0d ov%0d exp=0", fe_cnt - fe0, ov_cnt - ov0); end
        send_frame(8'hC3, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (data_out !== 8'hC3 || data_out_valid !== 1'b1) begin n_fail++; $display("FAIL gl_next got=%h/%b exp=c3/1", data_out, data_out_valid); end
        consume();
    endtask

    task automatic test_reset_midframe();
        int vr0;
        vr0 = vrise;
        fork
            send_frame(8'hFF, 1'b1);
            begin
                @(posedge clk);
                repeat (45) @(posedge clk);
                #1 rst = 1'b1;
                repeat (2) @(posedge clk);
                #1;
                n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL mrst_data got=%h exp=00", data_out); end
                n_checks++; if (data_out_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_valid got=%b exp=0", data_out_valid); end
                n_checks++; if (framing_error !== 1'b0 || overrun !== 1'b0) begin n_fail++; $display("FAIL mrst_flags got=%b%b exp=00", framing_error, overrun); end
                rst = 1'b0;
            end
        join
        repeat (20) @(posedge clk);
        #1;
        n_checks++; if (vrise - vr0 != 0 || data_out_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_partial got=%0d rises exp=0", vrise - vr0); end
        send_frame(8'h01, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (data_out !== 8'h01 || data_out_valid !== 1'b1) begin n_fail++; $display("FAIL mrst_next got=%h/%b exp=01/1", data_out, data_out_valid); end
        consume();
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_latency();
        test_overrun();
        test_reload();
        test_framing();
        test_glitch();
        test_reset_midframe();
        n_checks++; if (both_cnt != 0) begin n_fail++; $display("FAIL fe_ov_overlap got=%0d exp=0", both_cnt); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
